button_step_clock_gen: RTL

// - Input-side front end for board-level single-step CPU debug: turns raw push buttons into clean CPU stimulus.
// - Sits beside the seven-segment display path and runs on the 100 MHz board clock.
// - Synchronises and debounces the step and CPU-reset buttons.
// - Emits exactly one fixed-width step_clk pulse per accepted press, plus a debounced cpu_rst level for the core.

---
 rtl/btn_clk_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 70 +++++++
 rtl/button_step_clock_gen.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/btn_clk_pkg.sv
// Shared types and defaults for the button-driven single-step clock front end.
// Contents:
//   step_state_e     - step FSM states (IDLE, HIGH, WAIT_REL)
//   DEF_*            - default parameter values for a 100 MHz board clock
//   cnt_width()      - counter width for a terminal count, never below 1 bit
package btn_clk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIGH     = 2'd1,
        WAIT_REL = 2'd2
    } step_state_e;

    localparam int DEF_DB_CYCLES   = 1_000_000;  // 10 ms at 100 MHz
    localparam int DEF_HIGH_CYCLES = 16;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_AUTO_DIV    = 50_000_000; // 1 Hz auto-run clock

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw push button.
// Ports:
//   clk      in   board clock
//   rst      in   synchronous active-high reset
//   btn_raw  in   asynchronous, bouncy button pin
//   level    out  debounced button level
//   rise     out  one-cycle pulse, registered, on each 0->1 of level
module btn_debounce
    import btn_clk_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int              DB_W    = cnt_width(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_TERM = DB_W'(DB_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;
    logic            stable_dly_q, stable_dly_d;
    logic            rise_q, rise_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        // Any sample that agrees with the accepted level restarts the count,
        // so only an unbroken run of DB_CYCLES disagreeing samples is accepted.
        if (sync2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_TERM) begin
            stable_d = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
        stable_dly_d = stable_q;
        rise_d       = stable_q & ~stable_dly_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            rise_q       <= 1'b0;
            db_cnt_q     <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            rise_q       <= rise_d;
            db_cnt_q     <= db_cnt_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;

endmodule

// File: rtl/button_step_clock_gen.sv
// Single-step CPU debug front end: debounced step button -> one fixed-width
// step_clk pulse per press, debounced CPU reset level, and a step counter.
// Optional feature macro: AUTO_RUN_EN (free-running step_clk when run_sw=1).
// Ports:
//   clk         in   100 MHz board clock
//   rst         in   synchronous active-high reset
//   btn_step    in   raw step button (async, bouncy)
//   btn_rst     in   raw CPU-reset button (async, bouncy)
//   run_sw      in   auto-run select, only used when AUTO_RUN_EN is defined
//   step_clk    out  clock to the CPU core
//   cpu_rst     out  debounced CPU reset level
//   step_count  out  step_clk rising edges since reset / cpu_rst
//   busy        out  high whenever the step FSM is not IDLE
module button_step_clock_gen
    import btn_clk_pkg::*;
#(
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int AUTO_DIV    = DEF_AUTO_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_step,
    input  logic             btn_rst,
    input  logic             run_sw,
    output logic             step_clk,
    output logic             cpu_rst,
    output logic [CNT_W-1:0] step_count,
    output logic             busy
);

    localparam int              HC_W      = cnt_width(HIGH_CYCLES);
    localparam logic [HC_W-1:0] HIGH_TERM = HC_W'(HIGH_CYCLES - 1);

    logic step_level, step_press;
    logic rst_level, unused_rst_rise;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_step),
        .level   (step_level),
        .rise    (step_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_rst_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_rst),
        .level   (rst_level),
        .rise    (unused_rst_rise)
    );

    step_state_e      state_q, state_d;
    logic [HC_W-1:0]  high_cnt_q, high_cnt_d;
    logic             step_clk_q, step_clk_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] step_count_q, step_count_d;

`ifdef AUTO_RUN_EN
    localparam int              DIV_W    = cnt_width(AUTO_DIV);
    localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(AUTO_DIV - 1);
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
`else
    localparam int unused_auto_div = AUTO_DIV;
    logic unused_run_sw;
    assign unused_run_sw = run_sw;
`endif

    always_comb begin
        state_d      = state_q;
        high_cnt_d   = high_cnt_q;
        step_clk_d   = 1'b0;
        step_count_d = step_count_q;
        cpu_rst_d    = rst_level;
`ifdef AUTO_RUN_EN
        // Divider sits at 0 whenever auto-run is off, so each run starts
        // with a full low half-period.
        div_cnt_d = '0;
        if (run_sw) begin
            state_d    = IDLE;
            high_cnt_d = '0;
            step_clk_d = step_clk_q;
            if (div_cnt_q == DIV_TERM) begin
                step_clk_d = ~step_clk_q;
                if (!step_clk_q) begin
                    step_count_d = step_count_q + CNT_W'(1);
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end else begin
`endif
            // step_clk is decided afresh every cycle, so leaving auto-run
            // drops it to 0 on the next edge.
            case (state_q)
                IDLE: begin
                    if (step_press) begin
                        state_d      = HIGH;
                        high_cnt_d   = '0;
                        step_clk_d   = 1'b1;
                        step_count_d = step_count_q + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (high_cnt_q == HIGH_TERM) begin
                        state_d = WAIT_REL;
                    end else begin
                        high_cnt_d = high_cnt_q + HC_W'(1);
                        step_clk_d = 1'b1;
                    end
                end
                WAIT_REL: begin
                    // Holding the button parks here, so one press = one step.
                    if (!step_level) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
`ifdef AUTO_RUN_EN
        end
`endif
        // Core still gets edges while in reset, but they are not counted.
        if (cpu_rst_q) begin
            step_count_d = '0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            high_cnt_q   <= '0;
            step_clk_q   <= 1'b0;
            cpu_rst_q    <= 1'b0;
            busy_q       <= 1'b0;
            step_count_q <= '0;
`ifdef AUTO_RUN_EN
            div_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            high_cnt_q   <= high_cnt_d;
            step_clk_q   <= step_clk_d;
            cpu_rst_q    <= cpu_rst_d;
            busy_q       <= busy_d;
            step_count_q <= step_count_d;
`ifdef AUTO_RUN_EN
            div_cnt_q    <= div_cnt_d;
`endif
        end
    end

    assign step_clk   = step_clk_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign step_count = step_count_q;

endmodule
